// File: rtl/cmos_pixel_packer_if.sv
`default_nettype none
// ============================================================================
//  Module      : cmos_pixel_packer_if
//  Description : Pixel stream bundle between a CMOS-style source and the
//                pixel packer, plus the packed-word stream toward the video
//                buffer.
//  Signals     : pix_data_i  - raw pixel sample (PIX_WDT bits)
//                fv_i, lv_i  - frame / line valid from the source
//                cam_data_o  - 32-bit packed word
//                cam_dvld_o  - packed word valid
//                cam_fv_o    - frame valid aligned to the packed stream
//                cam_lv_o    - write qualifier (mirrors cam_dvld_o)
//  Modports    : master - drives the pixel stream, observes packed output
//                slave  - the packer itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface cmos_pixel_packer_if #(
    parameter int PIX_WDT = 10
);
    logic [PIX_WDT-1:0] pix_data_i;
    logic               fv_i;
    logic               lv_i;
    logic [31:0]        cam_data_o;
    logic               cam_dvld_o;
    logic               cam_fv_o;
    logic               cam_lv_o;

    modport master (
        output pix_data_i, fv_i, lv_i,
        input  cam_data_o, cam_dvld_o, cam_fv_o, cam_lv_o
    );

    modport slave (
        input  pix_data_i, fv_i, lv_i,
        output cam_data_o, cam_dvld_o, cam_fv_o, cam_lv_o
    );
endinterface
`default_nettype wire

// File: rtl/cmos_pixel_packer.sv
`default_nettype none
// ============================================================================
//  Module      : cmos_pixel_packer
//  Description : Captures frames from a CMOS-style pixel bus (fv/lv/data),
//                packs pixel pairs into 32-bit words (first pixel in the low
//                half), flushes odd half words at line end, and checks line
//                length and frame height against programmed expectations.
//  Ports       : clk_i          - pixel clock
//                rstn_i         - asynchronous active-low reset
//                enable_i       - capture enable, sampled only while idle
//                frame_width_i  - expected pixels per line (latched per frame)
//                frame_height_i - expected lines per frame (latched per frame)
//                cam_if         - pixel input / packed output stream
//                line_err_o     - one-cycle pulse, line length mismatch
//                frame_err_o    - one-cycle pulse, frame height mismatch
//                frame_cnt_o    - completed frame count (wrapping)
//  Revision    : 1.0 - initial release
// ============================================================================
module cmos_pixel_packer #(
    parameter int PIX_WDT = 10,
    parameter int CNT_WDT = 16
) (
    input  wire                 clk_i,
    input  wire                 rstn_i,
    input  wire                 enable_i,
    input  wire [CNT_WDT-1:0]   frame_width_i,
    input  wire [CNT_WDT-1:0]   frame_height_i,
    cmos_pixel_packer_if.slave  cam_if,
    output logic                line_err_o,
    output logic                frame_err_o,
    output logic [CNT_WDT-1:0]  frame_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_LINE  = 2'd2
    } state_t;

    localparam logic [CNT_WDT-1:0] c_CNT_MAX = {CNT_WDT{1'b1}};
    localparam logic [CNT_WDT-1:0] c_CNT_ONE = CNT_WDT'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_frame_start;
    logic               w_frame_end;
    logic               w_line_start;
    logic               w_line_end;
    logic               w_pix_vld;

    logic [PIX_WDT-1:0] w_pix;
    logic [15:0]        w_pix_ext;
    logic               w_fv;
    logic               w_lv;

    logic               r_fv_prev;
    logic               r_fv_d1;
    logic               r_fv_d2;

    logic [CNT_WDT-1:0] r_pix_cnt;
    logic [CNT_WDT-1:0] r_line_cnt;
    logic [CNT_WDT-1:0] w_pix_cnt_inc;
    logic [CNT_WDT-1:0] w_line_cnt_inc;
    logic [CNT_WDT-1:0] r_width;
    logic [CNT_WDT-1:0] r_height;
    logic [CNT_WDT-1:0] r_frame_cnt;

    logic [15:0]        r_half;
    logic               r_half_vld;
    logic [31:0]        r_data;
    logic               r_dvld;
    logic               r_line_err;
    logic               r_frame_err;

    assign w_pix     = cam_if.pix_data_i;
    assign w_pix_ext = 16'(w_pix);
    assign w_fv      = cam_if.fv_i;
    assign w_lv      = cam_if.lv_i;

    assign w_pix_cnt_inc  = (r_pix_cnt  == c_CNT_MAX) ? r_pix_cnt  : r_pix_cnt  + c_CNT_ONE;
    assign w_line_cnt_inc = (r_line_cnt == c_CNT_MAX) ? r_line_cnt : r_line_cnt + c_CNT_ONE;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and per-edge control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_frame_start = 1'b0;
        w_frame_end   = 1'b0;
        w_line_start  = 1'b0;
        w_line_end    = 1'b0;
        w_pix_vld     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Only a genuine fv rise starts capture; a frame already in
                // flight when enable comes up is skipped entirely.
                if (enable_i && w_fv && !r_fv_prev) begin
                    w_state_nxt   = ST_FRAME;
                    w_frame_start = 1'b1;
                end
            end
            ST_FRAME: begin
                if (!w_fv) begin
                    w_state_nxt = ST_IDLE;
                    w_frame_end = 1'b1;
                end else if (w_lv) begin
                    w_state_nxt  = ST_LINE;
                    w_line_start = 1'b1;
                    w_pix_vld    = 1'b1;
                end
            end
            ST_LINE: begin
                if (!w_fv || !w_lv) begin
                    w_line_end  = 1'b1;
                    if (!w_fv) begin
                        w_state_nxt = ST_IDLE;
                        w_frame_end = 1'b1;
                    end else begin
                        w_state_nxt = ST_FRAME;
                    end
                end else begin
                    w_pix_vld = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Packing datapath, counters and checks
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            // fv history starts high so a frame already running when reset
            // releases is not mistaken for a fresh frame start.
            r_fv_prev   <= 1'b1;
            r_fv_d1     <= 1'b0;
            r_fv_d2     <= 1'b0;
            r_pix_cnt   <= '0;
            r_line_cnt  <= '0;
            r_width     <= '0;
            r_height    <= '0;
            r_frame_cnt <= '0;
            r_half      <= '0;
            r_half_vld  <= 1'b0;
            r_data      <= '0;
            r_dvld      <= 1'b0;
            r_line_err  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_dvld      <= 1'b0;
            r_line_err  <= 1'b0;
            r_frame_err <= 1'b0;
            r_fv_prev   <= w_fv;

            // Two-stage delay keeps cam_fv high until the last flush word
            // has been presented.
            r_fv_d1 <= w_fv && (r_state != ST_IDLE);
            r_fv_d2 <= r_fv_d1;

            if (w_frame_start) begin
                r_line_cnt <= '0;
                r_width    <= frame_width_i;
                r_height   <= frame_height_i;
            end

            if (w_pix_vld) begin
                if (w_line_start) begin
                    // Pair alignment restarts with every line.
                    r_pix_cnt  <= c_CNT_ONE;
                    r_half     <= w_pix_ext;
                    r_half_vld <= 1'b1;
                end else begin
                    r_pix_cnt <= w_pix_cnt_inc;
                    if (r_half_vld) begin
                        r_data     <= {w_pix_ext, r_half};
                        r_dvld     <= 1'b1;
                        r_half_vld <= 1'b0;
                    end else begin
                        r_half     <= w_pix_ext;
                        r_half_vld <= 1'b1;
                    end
                end
            end

            if (w_line_end) begin
                if (r_half_vld) begin
                    r_data     <= {16'h0000, r_half};
                    r_dvld     <= 1'b1;
                    r_half_vld <= 1'b0;
                end
                r_line_err <= (r_pix_cnt != r_width);
                r_line_cnt <= w_line_cnt_inc;
            end

            if (w_frame_end) begin
                // When lv and fv drop together the closing line counts.
                r_frame_err <= ((w_line_end ? w_line_cnt_inc : r_line_cnt) != r_height);
                r_frame_cnt <= r_frame_cnt + c_CNT_ONE;
            end
        end
    end

    assign cam_if.cam_data_o = r_data;
    assign cam_if.cam_dvld_o = r_dvld;
    assign cam_if.cam_lv_o   = r_dvld;
    assign cam_if.cam_fv_o   = r_fv_d2;
    assign line_err_o        = r_line_err;
    assign frame_err_o       = r_frame_err;
    assign frame_cnt_o       = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cmos_pixel_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmos_pixel_packer
//  Description : Self-checking bench for cmos_pixel_packer. Cycle vectors
//                carry inputs and the outputs expected right after the edge
//                that samples them. Frames are described as line-length
//                lists; expected words, error pulses and counts are derived
//                from that description with plain arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cmos_pixel_packer;

    localparam int c_PIX_WDT = 10;
    localparam int c_CNT_WDT = 8;
    localparam int c_CNT_MAX = (1 << c_CNT_WDT) - 1;

    typedef struct {
        bit          en;
        bit          fv;
        bit          lv;
        logic [9:0]  pix;
        int          fw;
        int          fh;
        bit          g;     // capture-gated fv at this edge (feeds cam_fv two edges on)
        bit          dv;
        logic [31:0] data;
        bit          le;
        bit          fe;
        int          fc;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 enable;
    logic [c_CNT_WDT-1:0] fw;
    logic [c_CNT_WDT-1:0] fh;
    logic                 line_err;
    logic                 frame_err;
    logic [c_CNT_WDT-1:0] fcnt;

    cmos_pixel_packer_if #(.PIX_WDT(c_PIX_WDT)) cam_if ();

    cmos_pixel_packer #(
        .PIX_WDT (c_PIX_WDT),
        .CNT_WDT (c_CNT_WDT)
    ) dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .enable_i       (enable),
        .frame_width_i  (fw),
        .frame_height_i (fh),
        .cam_if         (cam_if.slave),
        .line_err_o     (line_err),
        .frame_err_o    (frame_err),
        .frame_cnt_o    (fcnt)
    );

    always #5 clk = ~clk;

    int   n_vec  = 0;
    int   n_err  = 0;
    bit   prev_g = 1'b0;
    int   m_fcnt = 0;
    vec_t vq[$];
    vec_t tbl[$];
    int   line_len[$];

    function automatic int sat(input int x);
        return (x > c_CNT_MAX) ? c_CNT_MAX : x;
    endfunction

    function automatic logic [9:0] rp();
        return 10'($urandom);
    endfunction

    function automatic vec_t mk(input bit en, input bit fv, input bit lv, input logic [9:0] pix,
                                input int wd, input int ht, input bit g, input bit dv,
                                input logic [31:0] d, input bit le, input bit fe, input int fc);
        vec_t v;
        v.en = en; v.fv = fv; v.lv = lv; v.pix = pix; v.fw = wd; v.fh = ht;
        v.g = g; v.dv = dv; v.data = d; v.le = le; v.fe = fe; v.fc = fc;
        return v;
    endfunction

    task automatic push(input bit en, input bit fv, input bit lv, input logic [9:0] pix,
                        input int wd, input int ht, input bit g, input bit dv,
                        input logic [31:0] d, input bit le, input bit fe);
        vq.push_back(mk(en, fv, lv, pix, wd, ht, g, dv, d, le, fe, m_fcnt));
    endtask

    task automatic check_vec(input string tag, input int idx, input vec_t v);
        bit ok;
        n_vec++;
        ok = (cam_if.cam_dvld_o === v.dv) && (cam_if.cam_lv_o === v.dv) &&
             (!v.dv || (cam_if.cam_data_o === v.data)) &&
             (cam_if.cam_fv_o === prev_g) && (line_err === v.le) &&
             (frame_err === v.fe) && (fcnt === c_CNT_WDT'(v.fc));
        if (!ok) begin
            n_err++;
            $display("FAIL %s[%0d]: got dv=%b lv=%b data=%h fv=%b le=%b fe=%b fcnt=%0d, want dv=%b data=%h fv=%b le=%b fe=%b fcnt=%0d",
                     tag, idx, cam_if.cam_dvld_o, cam_if.cam_lv_o, cam_if.cam_data_o, cam_if.cam_fv_o,
                     line_err, frame_err, fcnt, v.dv, v.data, prev_g, v.le, v.fe, v.fc);
        end
        prev_g = v.g;
    endtask

    task automatic check_zero(input string tag);
        n_vec++;
        if (cam_if.cam_dvld_o !== 1'b0 || cam_if.cam_lv_o !== 1'b0 || cam_if.cam_data_o !== 32'h0 ||
            cam_if.cam_fv_o !== 1'b0 || line_err !== 1'b0 || frame_err !== 1'b0 || fcnt !== '0) begin
            n_err++;
            $display("FAIL %s: got dv=%b lv=%b data=%h fv=%b le=%b fe=%b fcnt=%0d, want all zero",
                     tag, cam_if.cam_dvld_o, cam_if.cam_lv_o, cam_if.cam_data_o, cam_if.cam_fv_o,
                     line_err, frame_err, fcnt);
        end
    endtask

    task automatic apply_q(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            enable            = vq[i].en;
            cam_if.fv_i       = vq[i].fv;
            cam_if.lv_i       = vq[i].lv;
            cam_if.pix_data_i = vq[i].pix;
            fw                = c_CNT_WDT'(vq[i].fw);
            fh                = c_CNT_WDT'(vq[i].fh);
            @(posedge clk);
            #1;
            check_vec(tag, i, vq[i]);
        end
        vq.delete();
    endtask

    // One frame from a line-length list. cap: enable at the fv rise;
    // en_mid: enable for the rest of the frame; together: last line's lv
    // falls on the same edge as fv. wd/ht are presented only at the rise,
    // random values afterwards must be ignored.
    task automatic build_frame(input bit cap, input bit en_mid, input int nl, input bit together,
                               input int wd, input int ht, input bit noise);
        int         lc;
        int         len;
        bit         tog;
        bit         lerr;
        bit         ferr;
        logic [9:0] p;
        logic [9:0] prv;
        lc  = 0;
        prv = '0;
        push(cap, 1'b0, noise & 1'($urandom), rp(), wd, ht, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        push(cap, 1'b1, 1'b0, rp(), wd, ht, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat ($urandom_range(0, 2))
            push(en_mid, 1'b1, 1'b0, rp(), $urandom_range(0, c_CNT_MAX), $urandom_range(0, c_CNT_MAX),
                 cap, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < nl; i++) begin
            len = line_len[i];
            for (int k = 0; k < len; k++) begin
                p = rp();
                push(en_mid, 1'b1, 1'b1, p, $urandom_range(0, c_CNT_MAX), $urandom_range(0, c_CNT_MAX),
                     cap, cap && (k % 2 == 1), {6'b0, p, 6'b0, prv}, 1'b0, 1'b0);
                prv = p;
            end
            tog  = together && (i == nl - 1);
            lerr = cap && (sat(len) != wd);
            ferr = 1'b0;
            if (cap) lc = sat(lc + 1);
            if (tog && cap) begin
                ferr   = (lc != ht);
                m_fcnt = (m_fcnt + 1) % (c_CNT_MAX + 1);
            end
            push(en_mid, !tog, 1'b0, rp(), $urandom_range(0, c_CNT_MAX), $urandom_range(0, c_CNT_MAX),
                 cap && !tog, cap && (len % 2 == 1), {22'b0, prv}, lerr, ferr);
            if (!tog)
                repeat ($urandom_range(0, 2))
                    push(en_mid, 1'b1, 1'b0, rp(), $urandom_range(0, c_CNT_MAX), $urandom_range(0, c_CNT_MAX),
                         cap, 1'b0, 32'h0, 1'b0, 1'b0);
        end
        if (!(together && nl > 0)) begin
            ferr = cap && (lc != ht);
            if (cap) m_fcnt = (m_fcnt + 1) % (c_CNT_MAX + 1);
            push(en_mid, 1'b0, 1'b0, rp(), wd, ht, 1'b0, 1'b0, 32'h0, 1'b0, ferr);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // width 4 / height 2, pixels 1..8, then width 3 / height 1, odd line
        tbl.push_back(mk(1, 0, 0, 10'h000, 4, 2, 0, 0, 32'h0,        0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 10'h000, 4, 2, 0, 0, 32'h0,        0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 10'h001, 4, 2, 1, 0, 32'h0,        0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 10'h002, 4, 2, 1, 1, 32'h00020001, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 10'h003, 4, 2, 1, 0, 32'h0,        0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 10'h004, 4, 2, 1, 1, 32'h00040003, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 10'h000, 4, 2, 1, 0, 32'h0,        0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 10'h005, 4, 2, 1, 0, 32'h0,        0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 10'h006, 4, 2, 1, 1, 32'h00060005, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 10'h007, 4, 2, 1, 0, 32'h0,        0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 10'h008, 4, 2, 1, 1, 32'h00080007, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 10'h000, 4, 2, 1, 0, 32'h0,        0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 10'h000, 4, 2, 0, 0, 32'h0,        0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 10'h000, 4, 2, 0, 0, 32'h0,        0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 10'h000, 4, 2, 0, 0, 32'h0,        0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 10'h000, 3, 1, 0, 0, 32'h0,        0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 10'h3FF, 3, 1, 1, 0, 32'h0,        0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 10'h001, 3, 1, 1, 1, 32'h000103FF, 0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 10'h2AA, 3, 1, 1, 0, 32'h0,        0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 10'h000, 3, 1, 1, 1, 32'h000002AA, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 10'h000, 3, 1, 0, 0, 32'h0,        0, 0, 2));
        tbl.push_back(mk(1, 0, 0, 10'h000, 3, 1, 0, 0, 32'h0,        0, 0, 2));

        rstn = 1'b0; enable = 1'b0; fw = '0; fh = '0;
        cam_if.fv_i = 1'b0; cam_if.lv_i = 1'b0; cam_if.pix_data_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rstn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) vq.push_back(tbl[i]);
        apply_q("table");
        m_fcnt = 2;

        // Long line and line error, too few lines and frame error
        line_len = '{5};
        build_frame(1, 1, 1, 0, 4, 2, 0);
        apply_q("line_frame_err");

        // Enable raised mid-frame: that frame skipped, next one captured
        line_len = '{4, 3};
        build_frame(0, 1, 2, 0, 4, 2, 1);
        build_frame(1, 0, 2, 0, 4, 2, 0);
        apply_q("late_enable");

        // Pixel and line counter saturation
        line_len = '{300};
        build_frame(1, 1, 1, 0, 255, 1, 0);
        build_frame(1, 1, 1, 1, 44, 1, 0);
        line_len.delete();
        for (int i = 0; i < 260; i++) line_len.push_back(1);
        build_frame(1, 1, 260, 0, 1, 255, 0);
        apply_q("saturation");

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            int nl;
            nl = $urandom_range(0, 4);
            line_len.delete();
            for (int i = 0; i < nl; i++) line_len.push_back($urandom_range(1, 9));
            build_frame($urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)), nl,
                        1'($urandom_range(0, 1)), $urandom_range(1, 9), $urandom_range(0, 4),
                        1'($urandom_range(0, 1)));
        end
        apply_q("random");

        // Reset one pixel into a line: no flush, wait for next fv rise
        push(1, 0, 0, rp(), 4, 1, 0, 0, 32'h0, 0, 0);
        push(1, 1, 0, rp(), 4, 1, 0, 0, 32'h0, 0, 0);
        push(1, 1, 1, rp(), 4, 1, 1, 0, 32'h0, 0, 0);
        apply_q("pre_reset");
        #2 rstn = 1'b0;
        #1 check_zero("reset_async");
        @(posedge clk); #1 check_zero("reset_hold1");
        @(posedge clk); #1 check_zero("reset_hold2");
        rstn   = 1'b1;
        prev_g = 1'b0;
        m_fcnt = 0;
        repeat (3) push(1, 1, 1, rp(), 4, 1, 0, 0, 32'h0, 0, 0);
        push(1, 1, 0, rp(), 4, 1, 0, 0, 32'h0, 0, 0);
        line_len = '{4};
        build_frame(1, 1, 1, 0, 4, 1, 0);
        apply_q("post_reset");

        // Frame counter wrap; closing frame drops fv and lv together after 3 pixels
        line_len.delete();
        while (m_fcnt != c_CNT_MAX) build_frame(1, 1, 0, 0, 1, 0, 0);
        line_len = '{3};
        build_frame(1, 1, 1, 1, 3, 1, 0);
        push(1, 0, 0, rp(), 3, 1, 0, 0, 32'h0, 0, 0);
        push(1, 0, 0, rp(), 3, 1, 0, 0, 32'h0, 0, 0);
        apply_q("wrap_together");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cmos_pixel_packer.md
CMOS_PIXEL_PACKER -- requirements
Module: cmos_pixel_packer

Interface
REQ-001 Parameter PIX_WDT, default 10, width of one CMOS pixel sample.
REQ-002 Parameter CNT_WDT, default 16, width of pixel, line and frame counters.
REQ-003 clk_i  input  1  pixel clock, all logic on its rising edge; one clock domain only.
REQ-004 rstn_i  input  1  asynchronous active-low reset.
REQ-005 enable_i  input  1  capture enable, high = pack frames.
REQ-006 pix_data_i  input  PIX_WDT  CMOS pixel data from the MIPI-to-CMOS bridge.
REQ-007 fv_i  input  1  frame valid.
REQ-008 lv_i  input  1  line valid; a pixel is valid on any edge where fv_i and lv_i are both 1.
REQ-009 frame_width_i  input  CNT_WDT  expected pixels per line.
REQ-010 frame_height_i  input  CNT_WDT  expected lines per frame.
REQ-011 cam_data_o  output  32  packed word for the video buffer.
REQ-012 cam_dvld_o  output  1  cam_data_o valid, one word per asserted cycle.
REQ-013 cam_fv_o  output  1  frame valid aligned to the packed stream.
REQ-014 cam_lv_o  output  1  write qualifier, identical to cam_dvld_o.
REQ-015 line_err_o  output  1  one-cycle pulse: line length mismatch.
REQ-016 frame_err_o  output  1  one-cycle pulse: frame height mismatch.
REQ-017 frame_cnt_o  output  CNT_WDT  count of completed frames.

Function
REQ-018 FSM states: IDLE, FRAME (fv high, between lines), LINE (fv and lv high).
REQ-019 IDLE -> FRAME only on a sampled fv_i rising edge (fv_i=1, previous fv_i=0) with enable_i=1; fv_i already high at enable discards that partial frame.
REQ-020 FRAME -> LINE when lv_i=1; LINE -> FRAME when lv_i=0; FRAME or LINE -> IDLE when fv_i=0.
REQ-021 enable_i is sampled only in IDLE; deasserting it mid-frame lets the current frame complete.
REQ-022 lv_i=1 while fv_i=0, or any activity in IDLE, produces no output and no counter change.
REQ-023 Each pixel is zero-extended to 16 bits; the first pixel of a pair goes to cam_data_o[15:0], the second to [31:16].
REQ-024 The word is registered: cam_dvld_o=1 in the cycle after the edge that samples the second pixel of a pair.
REQ-025 Odd-length line: on the first edge sampling lv_i=0 (or fv_i=0) with a pending half word, emit it with [31:16]=0, same one-cycle latency.
REQ-026 Pair alignment restarts at every line start; no half word carries across lines.
REQ-027 cam_fv_o is fv_i gated by capture (FRAME/LINE), delayed two clocks, so it falls after the last flushed word.
REQ-028 Pixel counter clears at line start, increments per valid pixel, saturates at all-ones.
REQ-029 At line end, line_err_o pulses one cycle when pixel count != frame_width_i, in the same cycle as any flush word.
REQ-030 Line counter clears at frame start, increments at each line end, saturates at all-ones.
REQ-031 At frame end, frame_err_o pulses one cycle when line count != frame_height_i.
REQ-032 frame_cnt_o increments by 1 at each frame end, wraps all-ones -> 0.
REQ-033 fv_i and lv_i falling on the same edge: line end (flush, line check, line count) is processed first; the frame check uses the updated line count.
REQ-034 frame_width_i and frame_height_i are sampled at frame start and held for the frame.

Reset
REQ-035 rstn_i low forces IDLE; cam_data_o, cam_dvld_o, cam_fv_o, cam_lv_o, line_err_o, frame_err_o = 0; frame_cnt_o = 0; all counters, pending half word and delay registers cleared.
REQ-036 Reset asserted mid-line drops the pending half word and emits no flush; after release the block waits in IDLE for the next fv_i rising edge.

Verification
REQ-037 Width 4, height 2, pixels 0x001..0x008 -> 4 words: 0x00020001, 0x00040003, 0x00060005, 0x00080007; no errors; frame_cnt_o=1.
REQ-038 Width 3, one line 0x3FF,0x001,0x2AA -> words 0x000103FF then 0x000002AA on the lv fall edge; line_err_o=0.
REQ-039 frame_width_i=4, line of 5 pixels -> line_err_o one-cycle pulse at line end; frame_height_i=2 with 1 line -> frame_err_o pulse at fv fall.
REQ-040 enable_i raised while fv_i high -> no output for that frame; next full frame packed normally.
REQ-041 fv_i and lv_i fall together after 3 pixels -> flush word, then cam_fv_o low two clocks after fv_i fall; frame_cnt_o 0xFFFF -> 0x0000 wrap.
REQ-042 rstn_i pulsed low after 1 pixel of a line -> all outputs 0, no flush word, capture resumes only on the next fv_i rising edge.
